ws2812_stream: RTL and testbench

Buffered, parametrised WS2812-family LED strip driver. Accepts pixel words through a valid/ready handshake into a small FIFO and serialises them back-to-back with no inter-word gap, supporting 24-bit (RGB) and 32-bit (RGBW) pixels. Bit timing is derived from parameters, not fixed constants. Sits between the character-matrix pixel generator and the strip output pin.

---
 rtl/ws2812_pkg.sv | 33 +++
 rtl/ws2812_fifo.sv | 66 ++++++
 rtl/ws2812_stream.sv | 183 ++++++++++++++++++
 tb/tb_ws2812_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// ws2812_pkg : shared state encoding and timing helpers for the WS2812 driver
// Revision   : 1.0
// ============================================================================
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Floor of clk_hz * ns / 1e9, evaluated at elaboration.
    function automatic int ns_to_cycles(input longint clk_hz, input longint ns);
        return int'((clk_hz * ns) / 64'sd1000000000);
    endfunction

    function automatic bit bits_legal(input int bits);
        return (bits == 24) || (bits == 32);
    endfunction

    function automatic bit timing_legal(input int cyc_t1h, input int cyc_period,
                                        input int cyc_reset);
        return (cyc_t1h < cyc_period) && (cyc_reset < 65536);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_fifo.sv
`default_nettype none
// ============================================================================
// ws2812_fifo : synchronous first-word-fall-through FIFO for tagged pixels
// Revision    : 1.0
// ============================================================================
module ws2812_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk20,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_next
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_level == c_depth);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        level_next = r_level;
        if (w_do_push && !w_do_pop) begin
            level_next = r_level + (c_ptr_w + 1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            level_next = r_level - (c_ptr_w + 1)'(1);
        end
    end

    always_ff @(posedge clk20) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk20) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            r_level <= level_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_stream.sv
`default_nettype none
// ============================================================================
// ws2812_stream : buffered WS2812/SK6812 strip serialiser (RGB or RGBW words)
// Revision      : 1.0
// ============================================================================
module ws2812_stream
    import ws2812_pkg::*;
#(
    parameter int CLK_HZ     = 20000000,
    parameter int BITS       = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int T0H_NS     = 400,
    parameter int T1H_NS     = 800,
    parameter int PERIOD_NS  = 1250,
    parameter int RESET_US   = 300
) (
    input  logic                          clk20,
    input  logic                          reset,
    input  logic [BITS-1:0]               data_in,
    input  logic                          valid,
    input  logic                          latch,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          underrun,
    output logic                          led
);
    localparam int c_cyc_t0h    = ns_to_cycles(CLK_HZ, T0H_NS);
    localparam int c_cyc_t1h    = ns_to_cycles(CLK_HZ, T1H_NS);
    localparam int c_cyc_period = ns_to_cycles(CLK_HZ, PERIOD_NS);
    localparam int c_cyc_reset  = ns_to_cycles(CLK_HZ, RESET_US * 1000);
    localparam int c_bp_w       = $clog2(BITS);
    localparam int c_lvl_w      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [15:0]         c_t0h         = 16'(c_cyc_t0h);
    localparam logic [15:0]         c_t1h         = 16'(c_cyc_t1h);
    localparam logic [15:0]         c_period_last = 16'(c_cyc_period - 1);
    localparam logic [15:0]         c_reset_last  = 16'(c_cyc_reset - 1);
    localparam logic [c_bp_w-1:0]   c_bp_top      = c_bp_w'(BITS - 1);
    localparam logic [c_lvl_w-1:0]  c_depth       = c_lvl_w'(FIFO_DEPTH);

    if (!bits_legal(BITS)) begin : g_bad_bits
        $error("ws2812_stream: BITS must be 24 or 32");
    end
    if (!timing_legal(c_cyc_t1h, c_cyc_period, c_cyc_reset)) begin : g_bad_timing
        $error("ws2812_stream: T1H must be shorter than the period and reset below 65536 cycles");
    end
    if (!depth_legal(FIFO_DEPTH)) begin : g_bad_depth
        $error("ws2812_stream: FIFO_DEPTH must be a power of 2 in 2..16");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_time;
    logic [15:0]          w_time_next;
    logic [c_bp_w-1:0]    r_bitpos;
    logic [c_bp_w-1:0]    w_bitpos_next;
    logic [BITS-1:0]      r_shift;
    logic [BITS-1:0]      w_shift_next;
    logic                 r_latch;
    logic                 w_latch_next;
    logic                 r_led;
    logic                 w_led_next;
    logic                 r_underrun;
    logic                 w_underrun_next;
    logic                 r_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [BITS:0]        w_fifo_rd;
    logic [c_lvl_w-1:0]   w_level;
    logic [c_lvl_w-1:0]   w_level_next;

    assign w_push = valid && r_ready && !w_full;

    ws2812_fifo #(
        .WIDTH (BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk20      (clk20),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .wr_data    ({latch, data_in}),
        .rd_data    (w_fifo_rd),
        .full       (w_full),
        .empty      (w_empty),
        .level      (w_level),
        .level_next (w_level_next)
    );

    always_comb begin
        w_state_next    = r_state;
        w_time_next     = r_time;
        w_bitpos_next   = r_bitpos;
        w_shift_next    = r_shift;
        w_latch_next    = r_latch;
        w_pop           = 1'b0;
        w_underrun_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (r_time == c_period_last) begin
                    w_time_next = '0;
                    if (r_bitpos != '0) begin
                        w_bitpos_next = r_bitpos - c_bp_w'(1);
                        w_shift_next  = r_shift << 1;
                    end else if (r_latch) begin
                        w_state_next = LATCH;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next    = IDLE;
                        w_underrun_next = 1'b1;
                    end
                end else begin
                    w_time_next = r_time + 16'd1;
                end
            end
            LATCH: begin
                if (r_time == c_reset_last) begin
                    w_state_next = IDLE;
                    w_time_next  = '0;
                end else begin
                    w_time_next = r_time + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_time_next  = '0;
            end
        endcase

        // Every pop loads a fresh word at the top of its first bit.
        if (w_pop) begin
            w_shift_next  = w_fifo_rd[BITS-1:0];
            w_latch_next  = w_fifo_rd[BITS];
            w_bitpos_next = c_bp_top;
            w_time_next   = '0;
        end
    end

    // The line is retimed one cycle behind the serialiser state.
    assign w_led_next = (r_state == SEND) &&
                        (r_time < (r_shift[BITS-1] ? c_t1h : c_t0h));

    always_ff @(posedge clk20) begin
        if (reset) begin
            r_state    <= IDLE;
            r_time     <= '0;
            r_bitpos   <= '0;
            r_shift    <= '0;
            r_latch    <= 1'b0;
            r_led      <= 1'b0;
            r_underrun <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_time     <= w_time_next;
            r_bitpos   <= w_bitpos_next;
            r_shift    <= w_shift_next;
            r_latch    <= w_latch_next;
            r_led      <= w_led_next;
            r_underrun <= w_underrun_next;
            r_ready    <= (w_level_next < c_depth);
        end
    end

    assign ready      = r_ready;
    assign led        = r_led;
    assign underrun   = r_underrun;
    assign fifo_level = w_level;
    assign busy       = (r_state != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_stream.sv
`default_nettype none
// ============================================================================
// tb_ws2812_stream : directed self-checking bench for RGB and RGBW instances
// Revision         : 1.0
// ============================================================================
module tb_ws2812_stream;

    logic        clk20 = 1'b0;
    logic        reset = 1'b1;
    always #25 clk20 = ~clk20;

    logic [23:0] data24;
    logic        valid24, latch24, ready24, busy24, und24, led24;
    logic [2:0]  lvl24;
    logic [31:0] data32;
    logic        valid32, latch32, ready32, busy32, und32, led32;
    logic [2:0]  lvl32;

    ws2812_stream u_dut24 (
        .clk20(clk20), .reset(reset), .data_in(data24), .valid(valid24), .latch(latch24),
        .ready(ready24), .fifo_level(lvl24), .busy(busy24), .underrun(und24), .led(led24)
    );

    ws2812_stream #(.BITS(32)) u_dut32 (
        .clk20(clk20), .reset(reset), .data_in(data32), .valid(valid32), .latch(latch32),
        .ready(ready32), .fifo_level(lvl32), .busy(busy32), .underrun(und32), .led(led32)
    );

    int cyc = 0;
    always @(posedge clk20) cyc <= cyc + 1;

    // Pulse recorder: rise cycle and high length of every led pulse per instance.
    int   roff [2][256];
    int   hlen [2][256];
    int   np      [2] = '{0, 0};
    int   nund    [2] = '{0, 0};
    int   und_cyc [2] = '{0, 0};
    logic [1:0] led_v, und_v;
    logic [1:0] prev_v = 2'b00;
    assign led_v = {led32, led24};
    assign und_v = {und32, und24};

    always @(negedge clk20) begin
        for (int d = 0; d < 2; d++) begin
            if (led_v[d] && !prev_v[d]) begin
                if (np[d] < 256) begin
                    roff[d][np[d]] <= cyc;
                    hlen[d][np[d]] <= 1;
                    np[d]          <= np[d] + 1;
                end
            end else if (led_v[d] && np[d] > 0) begin
                hlen[d][np[d]-1] <= hlen[d][np[d]-1] + 1;
            end
            if (und_v[d]) begin
                nund[d]    <= nund[d] + 1;
                und_cyc[d] <= cyc;
            end
        end
        prev_v <= led_v;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk20);
    endtask

    task automatic wait_idle(input int d, input int bound, output int fall);
        fall = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!(d == 1 ? busy32 : busy24)) begin
                fall = cyc;
                break;
            end
        end
    endtask

    function automatic int bad_periods(input int d, input int a, input int n);
        int b = 0;
        for (int i = 0; i < n; i++)
            if (roff[d][a+i+1] - roff[d][a+i] != 25) b++;
        return b;
    endfunction

    function automatic int sum_high(input int d, input int a, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += hlen[d][a+i];
        return s;
    endfunction

    function automatic int count_len(input int d, input int a, input int n, input int len);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (hlen[d][a+i] == len) c++;
        return c;
    endfunction

    int exp_a5 [8] = '{16, 8, 16, 8, 8, 16, 8, 16};

    initial begin
        int base, e, fall, und0, held_ok, snap;
        data24 = '0; valid24 = 1'b0; latch24 = 1'b0;
        data32 = '0; valid32 = 1'b0; latch32 = 1'b0;
        repeat (3) tick();

        chk("rst_led",      led24, 0);
        chk("rst_ready",    ready24, 0);
        chk("rst_busy",     busy24, 0);
        chk("rst_level",    lvl24, 0);
        chk("rst_underrun", und24, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", ready24, 1);

        // Single latched word 0xA50000.
        base = np[0];
        data24 = 24'hA50000; latch24 = 1'b1; valid24 = 1'b1;
        tick(); e = cyc;
        valid24 = 1'b0; latch24 = 1'b0;
        chk("push_level", lvl24, 1);
        chk("push_busy",  busy24, 1);
        tick(); chk("lat_e1_led", led24, 0);
        tick(); chk("lat_e2_led", led24, 1);
        wait_idle(0, 8000, fall);
        chk("a5_busy_fall", fall, e + 6601);
        tick(); tick();
        chk("a5_pulses", np[0] - base, 24);
        chk("a5_first_rise", roff[0][base], e + 2);
        for (int i = 0; i < 8; i++) chk($sformatf("a5_high%0d", i), hlen[0][base+i], exp_a5[i]);
        chk("a5_periods", bad_periods(0, base, 23), 0);
        chk("a5_high_sum", sum_high(0, base, 24), 224);

        // Latched word, then four more fill the FIFO while it is sent, then a held fifth.
        base = np[0]; und0 = nund[0];
        data24 = 24'hFF00FF; latch24 = 1'b1; valid24 = 1'b1;
        tick(); e = cyc;
        data24 = 24'h800001; latch24 = 1'b0;
        tick(); chk("push_pop_level", lvl24, 1);
        data24 = 24'h0F0F0F; tick();
        data24 = 24'h000000; tick();
        data24 = 24'hFFFFFF; latch24 = 1'b1; tick();
        chk("full_level", lvl24, 4);
        chk("full_ready", ready24, 0);
        data24 = 24'h123456; latch24 = 1'b0;
        held_ok = 1;
        for (int i = 0; i < 8000 && ready24 == 1'b0; i++) begin
            tick();
            if (ready24 == 1'b0 && lvl24 != 3'd4) held_ok = 0;
        end
        chk("full_hold_level", held_ok, 1);
        chk("ready_reassert_cyc", cyc, e + 6602);
        chk("level_after_pop", lvl24, 3);
        tick();
        valid24 = 1'b0;
        chk("held_word_accepted", lvl24, 4);
        chk("ready_refull", ready24, 0);
        wait_idle(0, 10000, fall);
        chk("burst_busy_fall", fall, e + 15603);
        tick(); tick();
        chk("underrun_count", nund[0] - und0, 1);
        chk("underrun_cyc", und_cyc[0], e + 15603);
        chk("led_after_underrun", led24, 0);
        chk("burst_pulses", np[0] - base, 144);
        chk("ff_first_rise", roff[0][base], e + 2);
        chk("ff_high_sum", sum_high(0, base, 24), 320);
        chk("w0_first_rise", roff[0][base+24], e + 6603);
        chk("w_periods", bad_periods(0, base + 24, 95), 0);
        chk("w_high_sum", sum_high(0, base + 24, 96), 1072);
        chk("w4_first_rise", roff[0][base+120], e + 15004);
        chk("w4_high_sum", sum_high(0, base + 120, 24), 264);

        // RGBW instance: 0x00000001 with latch.
        base = np[1];
        data32 = 32'h00000001; latch32 = 1'b1; valid32 = 1'b1;
        tick(); e = cyc;
        valid32 = 1'b0; latch32 = 1'b0;
        wait_idle(1, 9000, fall);
        chk("rgbw_busy_fall", fall, e + 6801);
        tick(); tick();
        chk("rgbw_pulses", np[1] - base, 32);
        chk("rgbw_first_rise", roff[1][base], e + 2);
        chk("rgbw_zero_highs", count_len(1, base, 31, 8), 31);
        chk("rgbw_last_high", hlen[1][base+31], 16);
        chk("rgbw_periods", bad_periods(1, base, 31), 0);
        chk("rgbw_underrun", nund[1], 0);

        // Reset in the middle of a high phase with words still queued.
        und0 = nund[0];
        data24 = 24'hFFFFFF; latch24 = 1'b0; valid24 = 1'b1;
        tick(); e = cyc;
        data24 = 24'hAAAAAA; tick();
        data24 = 24'h555555; tick();
        valid24 = 1'b0;
        repeat (301) tick();
        chk("pre_reset_led",   led24, 1);
        chk("pre_reset_level", lvl24, 2);
        reset = 1'b1;
        tick();
        chk("mid_rst_led",   led24, 0);
        chk("mid_rst_level", lvl24, 0);
        chk("mid_rst_ready", ready24, 0);
        chk("mid_rst_busy",  busy24, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ready", ready24, 1);
        chk("post_rst_busy",  busy24, 0);
        tick();
        snap = np[0];
        repeat (700) tick();
        chk("no_residual_pulses", np[0] - snap, 0);
        chk("no_residual_led", led24, 0);
        chk("no_residual_underrun", nund[0] - und0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
